// File: rtl/pc_unit.sv
// pc_unit: 6502 program counter with per-half source select, increment with
// carry from PCL into PCH, bus drivers, and a post-reset vector fetch.
// Latency: 1 cycle from sampled controls to PC; bus outputs are combinational. Backpressure: none.
//
// Ports:
//   CLK, RST                  clock; synchronous active-high reset
//   PCL_LOAD, ADL_LOAD        low-half source select (ADL_LOAD wins)
//   PCH_LOAD, ADH_LOAD        high-half source select (ADH_LOAD wins)
//   INC                       add 1 to the selected {high,low} value
//   DB_L_EN, DB_H_EN          drive PCL / PCH onto DB_BUS (DB_L_EN wins)
//   ADL_EN, ADH_EN            drive PCL onto ADL_BUS, PCH onto ADH_BUS
//   ADL_DATA, ADH_DATA        address bus inputs for jumps
//   DB_DATA                   data bus input, used only by the vector fetch
//   DB_BUS, ADL_BUS, ADH_BUS  gated PC bytes, 0 when not enabled or busy
//   ADDR_OUT                  vector address while fetching, else {PCH,PCL}
//   PC                        current {PCH,PCL}
//   BUSY                      high during the vector fetch
//   PAGE_CARRY                one-cycle pulse: last increment carried into PCH
module pc_unit #(
    parameter int                        LOW_W        = 8,
    parameter int                        HIGH_W       = 8,
    parameter logic [LOW_W+HIGH_W-1:0]   RESET_VECTOR = 16'hFFFC
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        PCL_LOAD,
    input  logic                        ADL_LOAD,
    input  logic                        PCH_LOAD,
    input  logic                        ADH_LOAD,
    input  logic                        INC,
    input  logic                        DB_L_EN,
    input  logic                        DB_H_EN,
    input  logic                        ADL_EN,
    input  logic                        ADH_EN,
    input  logic [LOW_W-1:0]            ADL_DATA,
    input  logic [HIGH_W-1:0]           ADH_DATA,
    input  logic [LOW_W-1:0]            DB_DATA,
    output logic [LOW_W-1:0]            DB_BUS,
    output logic [LOW_W-1:0]            ADL_BUS,
    output logic [HIGH_W-1:0]           ADH_BUS,
    output logic [LOW_W+HIGH_W-1:0]     ADDR_OUT,
    output logic [LOW_W+HIGH_W-1:0]     PC,
    output logic                        BUSY,
    output logic                        PAGE_CARRY
);

    localparam int PC_W  = LOW_W + HIGH_W;
    // Common width used to move bytes between halves of unequal size.
    localparam int MAX_W = (LOW_W > HIGH_W) ? LOW_W : HIGH_W;

    // The +1 wraps naturally because the sum is truncated to PC_W bits.
    localparam logic [PC_W-1:0] VEC_HI_ADDR = RESET_VECTOR + PC_W'(1);

    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [LOW_W-1:0]  pcl_q;
    logic [LOW_W-1:0]  pcl_d;
    logic [HIGH_W-1:0] pch_q;
    logic [HIGH_W-1:0] pch_d;
    logic              page_carry_q;
    logic              page_carry_d;

    logic [LOW_W-1:0]  sel_lo;
    logic [HIGH_W-1:0] sel_hi;
    logic [LOW_W:0]    lo_sum;
    logic              cy;

    // DB byte resized to the high half, and PCH resized to the DB width.
    logic [MAX_W-1:0]  db_wide;
    logic [HIGH_W-1:0] db_as_hi;
    logic [MAX_W-1:0]  pch_wide;
    logic [LOW_W-1:0]  pch_as_lo;

    assign db_wide   = MAX_W'(DB_DATA);
    assign db_as_hi  = db_wide[HIGH_W-1:0];
    assign pch_wide  = MAX_W'(pch_q);
    assign pch_as_lo = pch_wide[LOW_W-1:0];

    // Source select and increment datapath. PCL_LOAD/PCH_LOAD select the
    // recirculate path, which is the same value as hold; they are kept as
    // explicit priorities so the select reads like the original datapath.
    always_comb begin
        sel_lo = pcl_q;
        if (ADL_LOAD) begin
            sel_lo = ADL_DATA;
        end else if (PCL_LOAD) begin
            sel_lo = pcl_q;
        end

        sel_hi = pch_q;
        if (ADH_LOAD) begin
            sel_hi = ADH_DATA;
        end else if (PCH_LOAD) begin
            sel_hi = pch_q;
        end

        lo_sum = {1'b0, sel_lo} + (LOW_W+1)'(INC);
        cy     = lo_sum[LOW_W];
    end

    // Next-state and register-input logic.
    always_comb begin
        state_d      = state_q;
        pcl_d        = pcl_q;
        pch_d        = pch_q;
        page_carry_d = 1'b0;

        unique case (state_q)
            VEC_LO: begin
                pcl_d   = DB_DATA;
                state_d = VEC_HI;
            end
            VEC_HI: begin
                pch_d   = db_as_hi;
                state_d = RUN;
            end
            RUN: begin
                pcl_d        = lo_sum[LOW_W-1:0];
                pch_d        = sel_hi + HIGH_W'(cy);
                page_carry_d = cy;
            end
            default: begin
                state_d = VEC_LO;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= VEC_LO;
            pcl_q        <= '0;
            pch_q        <= '0;
            page_carry_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcl_q        <= pcl_d;
            pch_q        <= pch_d;
            page_carry_q <= page_carry_d;
        end
    end

    // Outputs. Bus drivers are gated off entirely while the fetch runs.
    always_comb begin
        BUSY     = (state_q != RUN);
        PC       = {pch_q, pcl_q};
        ADDR_OUT = {pch_q, pcl_q};
        DB_BUS   = '0;
        ADL_BUS  = '0;
        ADH_BUS  = '0;

        if (state_q == VEC_LO) begin
            ADDR_OUT = RESET_VECTOR;
        end else if (state_q == VEC_HI) begin
            ADDR_OUT = VEC_HI_ADDR;
        end

        if (!BUSY) begin
            if (DB_L_EN) begin
                DB_BUS = pcl_q;
            end else if (DB_H_EN) begin
                DB_BUS = pch_as_lo;
            end
            if (ADL_EN) begin
                ADL_BUS = pcl_q;
            end
            if (ADH_EN) begin
                ADH_BUS = pch_q;
            end
        end
    end

    assign PAGE_CARRY = page_carry_q;

endmodule
